mem_stage: RTL and testbench

Memory stage of the 5-stage MIPS pipeline, sitting directly downstream of the execute stage. It registers the execute-stage results into the EX/MEM pipeline register and performs word, halfword and byte loads and stores against a local data memory. It registers the load data and ALU result into the MEM/WB pipeline register. It also produces `ALUOutM` and `ResultW`, the two forwarding sources consumed by the execute stage's operand muxes.

---
 rtl/mem_stage_if.sv | 41 ++++
 rtl/mem_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
//==============================================================================
// Module   : mem_stage_if
// Brief    : Execute-to-memory pipeline bundle plus M/W results and forwarding.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface mem_stage_if;
    logic        RegWriteE;
    logic        MemtoRegE;
    logic        MemWriteE;
    logic [1:0]  MemSizeE;
    logic        MemSignE;
    logic [31:0] ALUOutE;
    logic [31:0] WriteDataE;
    logic [4:0]  WriteRegE;

    logic [31:0] ALUOutM;
    logic [4:0]  WriteRegM;
    logic        RegWriteM;
    logic        MisalignM;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;

    modport master (
        output RegWriteE, MemtoRegE, MemWriteE, MemSizeE, MemSignE,
               ALUOutE, WriteDataE, WriteRegE,
        input  ALUOutM, WriteRegM, RegWriteM, MisalignM,
               RegWriteW, WriteRegW, ResultW
    );

    modport slave (
        input  RegWriteE, MemtoRegE, MemWriteE, MemSizeE, MemSignE,
               ALUOutE, WriteDataE, WriteRegE,
        output ALUOutM, WriteRegM, RegWriteM, MisalignM,
               RegWriteW, WriteRegW, ResultW
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
//==============================================================================
// Module   : mem_stage
// Brief    : MIPS memory stage: EX/MEM and MEM/WB registers, sized loads/stores.
// Revision : 1.0
//==============================================================================
`default_nettype none

module mem_stage #(
    parameter int MEM_WORDS = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_stage_if.slave bus
);
    localparam int c_ADDR_W = $clog2(MEM_WORDS);

    logic        reg_write_m_q,  reg_write_m_d;
    logic        mem_to_reg_m_q, mem_to_reg_m_d;
    logic        mem_write_m_q,  mem_write_m_d;
    logic [1:0]  mem_size_m_q,   mem_size_m_d;
    logic        mem_sign_m_q,   mem_sign_m_d;
    logic [31:0] alu_out_m_q,    alu_out_m_d;
    logic [31:0] write_data_m_q, write_data_m_d;
    logic [4:0]  write_reg_m_q,  write_reg_m_d;

    logic        reg_write_w_q,  reg_write_w_d;
    logic        mem_to_reg_w_q, mem_to_reg_w_d;
    logic [4:0]  write_reg_w_q,  write_reg_w_d;
    logic [31:0] alu_out_w_q,    alu_out_w_d;
    logic [31:0] read_data_w_q,  read_data_w_d;

    logic [31:0] mem_q [MEM_WORDS];

    logic [c_ADDR_W-1:0] w_idx;
    logic                w_misaligned;
    logic                w_misalign_m;
    logic                w_store_en;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic [31:0]         w_rword;
    logic [31:0]         w_load_data;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;

    always_comb begin
        reg_write_m_d  = bus.RegWriteE;
        mem_to_reg_m_d = bus.MemtoRegE;
        mem_write_m_d  = bus.MemWriteE;
        mem_size_m_d   = bus.MemSizeE;
        mem_sign_m_d   = bus.MemSignE;
        alu_out_m_d    = bus.ALUOutE;
        write_data_m_d = bus.WriteDataE;
        write_reg_m_d  = bus.WriteRegE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            mem_write_m_q  <= 1'b0;
            mem_size_m_q   <= 2'b00;
            mem_sign_m_q   <= 1'b0;
            alu_out_m_q    <= 32'd0;
            write_data_m_q <= 32'd0;
            write_reg_m_q  <= 5'd0;
        end else begin
            reg_write_m_q  <= reg_write_m_d;
            mem_to_reg_m_q <= mem_to_reg_m_d;
            mem_write_m_q  <= mem_write_m_d;
            mem_size_m_q   <= mem_size_m_d;
            mem_sign_m_q   <= mem_sign_m_d;
            alu_out_m_q    <= alu_out_m_d;
            write_data_m_q <= write_data_m_d;
            write_reg_m_q  <= write_reg_m_d;
        end
    end

    // Upper address bits are dropped, so accesses wrap modulo 4*MEM_WORDS.
    assign w_idx = alu_out_m_q[c_ADDR_W+1:2];

    always_comb begin
        case (mem_size_m_q)
            2'b01:   w_misaligned = alu_out_m_q[0];
            2'b10:   w_misaligned = 1'b0;
            default: w_misaligned = (alu_out_m_q[1:0] != 2'b00);
        endcase
    end

    assign w_misalign_m = (mem_write_m_q | mem_to_reg_m_q) & w_misaligned;
    assign w_store_en   = rst_n & mem_write_m_q & ~w_misaligned;

    always_comb begin
        case (mem_size_m_q)
            2'b10: begin
                w_be    = 4'b0001 << alu_out_m_q[1:0];
                w_wdata = {4{write_data_m_q[7:0]}};
            end
            2'b01: begin
                w_be    = alu_out_m_q[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{write_data_m_q[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = write_data_m_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) mem_q[w_idx][i*8 +: 8] <= w_wdata[i*8 +: 8];
            end
        end
    end

    // Read is asynchronous, so a load alongside a store sees pre-store data.
    assign w_rword = mem_q[w_idx];

    always_comb begin
        w_load_data = w_rword;
        w_half      = alu_out_m_q[1] ? w_rword[31:16] : w_rword[15:0];
        case (alu_out_m_q[1:0])
            2'b00:   w_byte = w_rword[7:0];
            2'b01:   w_byte = w_rword[15:8];
            2'b10:   w_byte = w_rword[23:16];
            default: w_byte = w_rword[31:24];
        endcase
        case (mem_size_m_q)
            2'b10:   w_load_data = {{24{mem_sign_m_q & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{mem_sign_m_q & w_half[15]}}, w_half};
            default: w_load_data = w_rword;
        endcase
        if (w_misaligned) w_load_data = 32'd0;
    end

    always_comb begin
        reg_write_w_d  = reg_write_m_q & ~w_misalign_m;
        mem_to_reg_w_d = mem_to_reg_m_q;
        write_reg_w_d  = write_reg_m_q;
        alu_out_w_d    = alu_out_m_q;
        read_data_w_d  = w_load_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_write_w_q  <= 1'b0;
            mem_to_reg_w_q <= 1'b0;
            write_reg_w_q  <= 5'd0;
            alu_out_w_q    <= 32'd0;
            read_data_w_q  <= 32'd0;
        end else begin
            reg_write_w_q  <= reg_write_w_d;
            mem_to_reg_w_q <= mem_to_reg_w_d;
            write_reg_w_q  <= write_reg_w_d;
            alu_out_w_q    <= alu_out_w_d;
            read_data_w_q  <= read_data_w_d;
        end
    end

    assign bus.ALUOutM   = alu_out_m_q;
    assign bus.WriteRegM = write_reg_m_q;
    assign bus.RegWriteM = reg_write_m_q;
    assign bus.MisalignM = w_misalign_m;
    assign bus.RegWriteW = reg_write_w_q;
    assign bus.WriteRegW = write_reg_w_q;
    assign bus.ResultW   = mem_to_reg_w_q ? read_data_w_q : alu_out_w_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//==============================================================================
// Module   : tb_mem_stage
// Brief    : Directed self-checking bench for mem_stage.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_mem_stage;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mem_stage_if bus_if ();

    mem_stage #(.MEM_WORDS(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_e(input logic rw, input logic m2r, input logic mw,
                         input logic [1:0] size, input logic sgn,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wr);
        bus_if.RegWriteE  = rw;
        bus_if.MemtoRegE  = m2r;
        bus_if.MemWriteE  = mw;
        bus_if.MemSizeE   = size;
        bus_if.MemSignE   = sgn;
        bus_if.ALUOutE    = alu;
        bus_if.WriteDataE = wd;
        bus_if.WriteRegE  = wr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction from E; on return it sits in M.
    task automatic run(input logic rw, input logic m2r, input logic mw,
                       input logic [1:0] size, input logic sgn,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] wr);
        set_e(rw, m2r, mw, size, sgn, alu, wd, wr);
        tick();
    endtask

    task automatic nop();
        run(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        run(1'b0, 1'b0, 1'b1, size, 1'b0, addr, data, 5'd0);
    endtask

    task automatic load_chk(input string tag, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] exp);
        run(1'b1, 1'b1, 1'b0, size, sgn, addr, 32'd0, 5'd7);
        nop();
        check(tag, bus_if.ResultW, exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;

        // Reset with random E inputs held for two edges.
        set_e(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
              $urandom, $urandom, 5'($urandom));
        tick();
        set_e(1'b1, 1'b1, 1'b1, 2'b11, 1'b1, $urandom, $urandom, 5'd31);
        tick();
        check("rst_alu_out_m",   bus_if.ALUOutM, 32'd0);
        check("rst_write_reg_m", 32'(bus_if.WriteRegM), 32'd0);
        check("rst_reg_write_m", 32'(bus_if.RegWriteM), 32'd0);
        check("rst_misalign_m",  32'(bus_if.MisalignM), 32'd0);
        check("rst_reg_write_w", 32'(bus_if.RegWriteW), 32'd0);
        check("rst_write_reg_w", 32'(bus_if.WriteRegW), 32'd0);
        check("rst_result_w",    bus_if.ResultW, 32'd0);

        // ALU pass-through right after reset release.
        rst_n = 1'b1;
        run(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h55, 32'd0, 5'd3);
        check("alu_out_m",   bus_if.ALUOutM, 32'h55);
        check("write_reg_m", 32'(bus_if.WriteRegM), 32'd3);
        nop();
        check("alu_result_w",    bus_if.ResultW, 32'h55);
        check("alu_reg_write_w", 32'(bus_if.RegWriteW), 32'd1);
        check("alu_write_reg_w", 32'(bus_if.WriteRegW), 32'd3);

        // Word store immediately followed by dependent load.
        store(2'b00, 32'h10, 32'hDEADBEEF);
        run(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 5'd5);
        nop();
        check("st_ld_word",        bus_if.ResultW, 32'hDEADBEEF);
        check("st_ld_reg_write_w", 32'(bus_if.RegWriteW), 32'd1);
        check("st_ld_write_reg_w", 32'(bus_if.WriteRegW), 32'd5);

        // Sub-word stores then loads.
        store(2'b00, 32'h20, 32'h0);
        store(2'b10, 32'h21, 32'h000000AA);
        store(2'b01, 32'h22, 32'h00001234);
        load_chk("ld_word_20",        2'b00, 1'b0, 32'h20, 32'h1234AA00);
        load_chk("ld_byte_21_signed", 2'b10, 1'b1, 32'h21, 32'hFFFFFFAA);
        load_chk("ld_byte_21_uns",    2'b10, 1'b0, 32'h21, 32'h000000AA);
        load_chk("ld_half_22_signed", 2'b01, 1'b1, 32'h22, 32'h00001234);
        load_chk("ld_half_20_signed", 2'b01, 1'b1, 32'h20, 32'hFFFFAA00);
        load_chk("ld_byte_23_uns",    2'b10, 1'b0, 32'h23, 32'h00000012);

        // Misaligned word store is flagged and suppressed.
        store(2'b00, 32'h13, 32'hCAFEF00D);
        check("misalign_st_flag", 32'(bus_if.MisalignM), 32'd1);
        load_chk("misalign_st_unchanged", 2'b00, 1'b0, 32'h10, 32'hDEADBEEF);

        // Misaligned half load: no writeback and zero result.
        run(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h21, 32'd0, 5'd9);
        check("misalign_ld_flag", 32'(bus_if.MisalignM), 32'd1);
        nop();
        check("misalign_ld_reg_write_w", 32'(bus_if.RegWriteW), 32'd0);
        check("misalign_ld_result_w",    bus_if.ResultW, 32'd0);

        // ALU op with an unaligned result is not a memory access.
        run(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h3, 32'd0, 5'd4);
        check("alu_unaligned_no_flag", 32'(bus_if.MisalignM), 32'd0);
        nop();
        check("alu_unaligned_reg_write_w", 32'(bus_if.RegWriteW), 32'd1);

        // Address wrap modulo 1 KiB.
        store(2'b00, 32'h400, 32'h0BADF00D);
        load_chk("wrap_400_to_000", 2'b00, 1'b0, 32'h000, 32'h0BADF00D);

        // Combined store+load returns old contents; store still lands.
        store(2'b00, 32'h30, 32'h11111111);
        run(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h30, 32'h22222222, 5'd6);
        nop();
        check("st_ld_same_old", bus_if.ResultW, 32'h11111111);
        load_chk("st_ld_same_new", 2'b00, 1'b0, 32'h30, 32'h22222222);

        // Reset on the edge ending a store's M cycle suppresses it.
        store(2'b00, 32'h40, 32'h33333333);
        set_e(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h40, 32'h44444444, 5'd0);
        tick();
        rst_n = 1'b0;
        nop();
        check("midrst_alu_out_m", bus_if.ALUOutM, 32'd0);
        rst_n = 1'b1;
        load_chk("midrst_store_suppressed", 2'b00, 1'b0, 32'h40, 32'h33333333);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
